// File: rtl/cache_fill_fsm_pkg.sv
// Shared encodings and block geometry for the cache miss fill controller.
package cache_fill_fsm_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } state_e;

    localparam int          WORDS_PER_BLOCK   = 8;
    localparam int          WORD_IDX_W        = 3;
    localparam int          CNT_W             = 4;
    localparam logic [15:0] BLOCK_OFFSET_MASK = 16'hFFF0;

endpackage

// File: rtl/cache_fill_fsm_counter.sv
// Saturating word counter for the fill controller: synchronous clear, enable,
// and a terminal flag once TERM words have been counted.
module fill_counter
    import cache_fill_fsm_pkg::*;
#(
    parameter int TERM = WORDS_PER_BLOCK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             term_o
);

    logic [CNT_W-1:0] cnt_q;

    assign term_o = (cnt_q == CNT_W'(TERM));
    assign cnt_o  = cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n || clr_i) begin
            cnt_q <= '0;
        end else if (en_i && !term_o) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/full_adder.sv
// One-bit full adder; chained by the fill controller to form the address adder.
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic sum_o,
    output logic cout_o
);

    assign sum_o  = a_i ^ b_i ^ cin_i;
    assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss fill controller: issues the eight word reads of the missing
// block, steers each valid return into the data array, and writes the tag on the last word.
module cache_fill_fsm #(
    parameter int WORDS_PER_BLOCK = 8,
    parameter int ADDR_W          = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              miss_detected,
    input  logic [ADDR_W-1:0] miss_address,
    input  logic [15:0]       memory_data,
    input  logic              memory_data_valid,
    output logic              fsm_busy,
    output logic              mem_read_en,
    output logic [ADDR_W-1:0] memory_address,
    output logic              write_data_array,
    output logic [2:0]        word_index,
    output logic              write_tag_array,
    output logic              fill_done
);
    import cache_fill_fsm_pkg::*;

    // state   | meaning
    // IDLE    | waiting for a miss; fsm_busy follows miss_detected
    // FILL    | issuing reads and collecting returns for base_addr_q

    state_e            state_q;
    logic [ADDR_W-1:0] base_addr_q;

    logic [CNT_W-1:0]  issue_cnt;
    logic [CNT_W-1:0]  ret_cnt;
    logic              issue_term;
    logic              unused_ret_term;
    logic              start_fill;
    logic              issue_en;
    logic              ret_fire;
    logic              fill_last;
    logic [2:0]        word_sel;
    logic [ADDR_W-1:0] offset;
    logic [ADDR_W-1:0] addr_sum;
    logic [ADDR_W:0]   carry;
    logic              unused_carry;
    logic              unused_data;

    // The data array takes memory_data directly; this block only qualifies it.
    assign unused_data = ^memory_data;

    assign start_fill = (state_q == ST_IDLE) && miss_detected;
    assign issue_en   = (state_q == ST_FILL) && !issue_term;
    assign ret_fire   = (state_q == ST_FILL) && memory_data_valid;
    assign fill_last  = ret_fire && (ret_cnt == CNT_W'(WORDS_PER_BLOCK - 1));

    fill_counter #(.TERM(WORDS_PER_BLOCK)) u_issue_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (start_fill),
        .en_i   (issue_en),
        .cnt_o  (issue_cnt),
        .term_o (issue_term)
    );

    fill_counter #(.TERM(WORDS_PER_BLOCK)) u_ret_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (start_fill),
        .en_i   (ret_fire),
        .cnt_o  (ret_cnt),
        .term_o (unused_ret_term)
    );

    // Once all words are issued the address parks on the last word.
    assign word_sel = (issue_cnt > CNT_W'(WORDS_PER_BLOCK - 1)) ? 3'd7 : issue_cnt[2:0];
    assign offset   = {{(ADDR_W - 4){1'b0}}, word_sel, 1'b0};

    assign carry[0] = 1'b0;
    for (genvar i = 0; i < ADDR_W; i++) begin : gen_fa
        full_adder u_fa (
            .a_i    (base_addr_q[i]),
            .b_i    (offset[i]),
            .cin_i  (carry[i]),
            .sum_o  (addr_sum[i]),
            .cout_o (carry[i+1])
        );
    end
    assign unused_carry = carry[ADDR_W];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            base_addr_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (miss_detected) begin
                        base_addr_q <= miss_address & ADDR_W'(BLOCK_OFFSET_MASK);
                        state_q     <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (fill_last) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        fsm_busy         = 1'b0;
        mem_read_en      = 1'b0;
        memory_address   = '0;
        write_data_array = 1'b0;
        word_index       = '0;
        write_tag_array  = 1'b0;
        fill_done        = 1'b0;
        if (rst_n) begin
            fsm_busy         = (state_q == ST_FILL) || miss_detected;
            mem_read_en      = issue_en;
            memory_address   = addr_sum;
            write_data_array = ret_fire;
            word_index       = ret_cnt[WORD_IDX_W-1:0];
            write_tag_array  = fill_last;
            fill_done        = fill_last;
        end
    end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Self-checking bench for cache_fill_fsm: a fill-level reference model plus a
// latency-randomised memory model, with directed scenarios and random fills.
module tb_cache_fill_fsm;

    logic        clk;
    logic        rst_n;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic [15:0] memory_data;
    logic        memory_data_valid;
    logic        fsm_busy;
    logic        mem_read_en;
    logic [15:0] memory_address;
    logic        write_data_array;
    logic [2:0]  word_index;
    logic        write_tag_array;
    logic        fill_done;

    cache_fill_fsm dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .memory_data       (memory_data),
        .memory_data_valid (memory_data_valid),
        .fsm_busy          (fsm_busy),
        .mem_read_en       (mem_read_en),
        .memory_address    (memory_address),
        .write_data_array  (write_data_array),
        .word_index        (word_index),
        .write_tag_array   (write_tag_array),
        .fill_done         (fill_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model: one fill in flight, tracked as words issued / returned.
    bit          m_fill     = 0;
    logic [15:0] m_base     = '0;
    int          m_iss      = 0;
    int          m_ret      = 0;
    bit          m_after_rst = 0;

    // Memory model: in-order return queue of ready cycles.
    int          q_ready[$];
    bit          gap_mode = 0;
    int          lat_min  = 4;
    int          lat_max  = 4;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always begin
        logic        e_busy, e_rd, e_wd, e_tag;
        logic [15:0] e_addr;
        logic [2:0]  e_idx;
        logic        nv;
        @(negedge clk);
        cyc++;
        e_busy = 0; e_rd = 0; e_wd = 0; e_tag = 0; e_addr = '0; e_idx = '0;
        if (rst_n) begin
            if (!m_fill) begin
                e_busy = miss_detected;
            end else begin
                e_busy = 1;
                e_rd   = (m_iss < 8);
                e_addr = m_base + 16'(2 * m_iss);
                e_wd   = memory_data_valid;
                e_idx  = 3'(m_ret);
                e_tag  = memory_data_valid && (m_ret == 7);
            end
        end
        chk("fsm_busy", fsm_busy, e_busy);
        chk("mem_read_en", mem_read_en, e_rd);
        chk("write_data_array", write_data_array, e_wd);
        chk("write_tag_array", write_tag_array, e_tag);
        chk("fill_done", fill_done, e_tag);
        if (e_rd) chk("memory_address", memory_address, e_addr);
        if (e_wd) chk("word_index", word_index, e_idx);
        if (!rst_n || m_after_rst) begin
            chk("addr_zero_in_reset", memory_address, 16'h0);
            chk("index_zero_in_reset", word_index, 3'd0);
        end

        if (e_rd) q_ready.push_back(cyc + $urandom_range(lat_min, lat_max));
        if (!rst_n) begin
            m_fill = 0; m_base = '0; m_iss = 0; m_ret = 0; m_after_rst = 1;
        end else begin
            m_after_rst = 0;
            if (!m_fill) begin
                if (miss_detected) begin
                    m_fill = 1; m_base = miss_address & 16'hFFF0; m_iss = 0; m_ret = 0;
                end
            end else begin
                if (m_iss < 8) m_iss++;
                if (memory_data_valid) begin
                    m_ret++;
                    if (m_ret == 8) m_fill = 0;
                end
            end
        end

        nv = 0;
        if (q_ready.size() != 0 && q_ready[0] <= cyc + 1 && (!gap_mode || ($urandom % 3) != 0)) begin
            void'(q_ready.pop_front());
            nv = 1;
        end
        @(posedge clk);
        #2;
        memory_data_valid = nv;
        memory_data       = 16'($urandom);
    end

    task automatic drain(input int bound);
        int k = 0;
        miss_detected = 0;
        while ((m_fill || q_ready.size() != 0) && k < bound) begin
            tick();
            k++;
        end
        checks++;
        if (k >= bound) begin
            errors++;
            $display("FAIL drain: still busy after %0d cycles, required idle", k);
        end
        tick();
        tick();
    endtask

    task automatic fixed_latency();
        gap_mode = 0; lat_min = 4; lat_max = 4;
    endtask

    initial begin
        int wd_cnt;
        int k;
        rst_n = 0; miss_detected = 0; miss_address = '0;
        memory_data = '0; memory_data_valid = 0;
        repeat (3) tick();
        rst_n = 1;
        #3;
        chk("post_reset_busy", fsm_busy, 1'b0);
        chk("post_reset_addr", memory_address, 16'h0);

        // Directed 1: latency 4 fill of 0x1234.
        fixed_latency();
        tick();
        miss_detected = 1; miss_address = 16'h1234;
        #3;
        chk("t1_busy_c0", fsm_busy, 1'b1);
        for (int c = 1; c <= 13; c++) begin
            tick();
            if (c == 1) miss_detected = 0;
            #3;
            case (c)
                1:  chk("t1_addr_c1", memory_address, 16'h1230);
                5:  chk("t1_wda_c5", write_data_array, 1'b1);
                8:  chk("t1_addr_c8", memory_address, 16'h123E);
                11: chk("t1_done_c11", fill_done, 1'b0);
                12: begin
                    chk("t1_done_c12", fill_done, 1'b1);
                    chk("t1_tag_c12", write_tag_array, 1'b1);
                    chk("t1_idx_c12", word_index, 3'd7);
                end
                13: chk("t1_busy_c13", fsm_busy, 1'b0);
                default: ;
            endcase
        end
        drain(100);

        // Directed 2: gappy returns, count data writes up to fill_done.
        gap_mode = 1; lat_min = 2; lat_max = 6;
        tick();
        miss_detected = 1; miss_address = 16'h1234;
        tick();
        miss_detected = 0;
        wd_cnt = 0; k = 0;
        #3;
        while (!fill_done && k < 200) begin
            if (write_data_array) wd_cnt++;
            tick(); #3; k++;
        end
        if (write_data_array) wd_cnt++;
        chk("t2_done_seen", fill_done, 1'b1);
        chk("t2_writes", wd_cnt, 8);
        drain(100);

        // Directed 3: miss input changes mid-fill are ignored.
        fixed_latency();
        tick();
        miss_detected = 1; miss_address = 16'h1234;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (c >= 2) begin
                miss_address  = 16'h8000;
                miss_detected = $urandom % 2;
            end
            #3;
            if (c == 3) chk("t3_addr_c3", memory_address, 16'h1234);
            if (c == 8) chk("t3_addr_c8", memory_address, 16'h123E);
        end
        miss_detected = 0;
        drain(100);

        // Directed 4: reset in cycle 6 of a fill, late returns ignored.
        tick();
        miss_detected = 1; miss_address = 16'h1234;
        for (int c = 1; c <= 7; c++) begin
            tick();
            if (c == 1) miss_detected = 0;
            rst_n = (c != 6);
            #3;
            if (c == 7) begin
                chk("t4_busy_c7", fsm_busy, 1'b0);
                chk("t4_wda_c7", write_data_array, 1'b0);
                chk("t4_rd_c7", mem_read_en, 1'b0);
            end
        end
        drain(100);
        tick();
        miss_detected = 1; miss_address = 16'h0452;
        tick();
        miss_detected = 0;
        #3;
        chk("t4_new_addr", memory_address, 16'h0450);
        drain(100);

        // Directed 5: miss held across completion, second fill at 0xFFF0.
        tick();
        miss_detected = 1; miss_address = 16'h1234;
        for (int c = 1; c <= 21; c++) begin
            tick();
            if (c == 2)  miss_address = 16'hFFF4;
            if (c == 14) miss_detected = 0;
            #3;
            if (c == 13) chk("t5_busy_c13", fsm_busy, 1'b1);
            if (c == 14) chk("t5_addr_c14", memory_address, 16'hFFF0);
            if (c == 21) chk("t5_addr_c21", memory_address, 16'hFFFE);
        end
        drain(100);

        // Random fills: random address, latency, gaps, miss noise, occasional reset.
        for (int n = 0; n < 25; n++) begin
            int rst_at;
            gap_mode = $urandom % 2;
            lat_min  = $urandom_range(1, 3);
            lat_max  = lat_min + $urandom_range(0, 4);
            rst_at   = (($urandom % 4) == 0) ? $urandom_range(1, 12) : -1;
            tick();
            miss_detected = 1; miss_address = 16'($urandom);
            for (int c = 1; c < 60 && m_fill; c++) begin
                tick();
                if (c == rst_at) begin
                    rst_n = 0; miss_detected = 0;
                    tick();
                    rst_n = 1;
                    break;
                end
                miss_detected = $urandom % 2;
                miss_address  = 16'($urandom);
            end
            drain(300);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cache_fill_fsm.md
Name: cache_fill_fsm

Overview:
- Miss-handling controller between the CPU's instruction/data caches and the multi-cycle main memory.
- On a cache miss it fetches the 16-byte block (8 x 16-bit words) that contains the missing address.
- Each returned word is steered into the cache data array. The tag array is written when the last word arrives.
- The CPU is stalled through fsm_busy until the fill completes.

Parameters:
- WORDS_PER_BLOCK, 8, words fetched per fill; fixed at 8 for the 16-byte block.
- ADDR_W, 16, address width.

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- miss_detected  input  1  tag-compare miss from the cache, level-sensitive
- miss_address  input  16  byte address that missed
- memory_data  input  16  read data from main memory
- memory_data_valid  input  1  memory_data is valid this cycle
- fsm_busy  output  1  stall request to the pipeline
- mem_read_en  output  1  read request to memory this cycle
- memory_address  output  16  address of the request
- write_data_array  output  1  write memory_data into the data array at word_index
- word_index  output  3  word offset within the block for the data-array write
- write_tag_array  output  1  write the tag and valid bit for the filled block
- fill_done  output  1  one-cycle pulse when the fill completes

Behaviour:
- Clock and reset:
  - Single clock domain; all state updates on the rising edge of clk.
  - Reset is synchronous and active-low: rst_n sampled 0 at an edge forces the IDLE state, clears issue_cnt and ret_cnt, and clears base_addr.
  - Every output is 0 while in reset and in the cycle after reset.
- States: IDLE and FILL, with a 1-bit encoding.
- IDLE:
  - mem_read_en, write_data_array, write_tag_array and fill_done are 0.
  - fsm_busy equals miss_detected (combinational), so the pipeline stalls in the same cycle the miss is seen.
  - If miss_detected=1: latch base_addr = miss_address & 16'hFFF0, clear both counters, and go to FILL.
  - memory_data_valid is ignored in IDLE.
- FILL, address issue:
  - fsm_busy=1.
  - While issue_cnt < 8: mem_read_en=1, memory_address = base_addr + (issue_cnt << 1), then issue_cnt increments.
  - Addresses therefore go out on 8 consecutive cycles.
  - After 8 issues, mem_read_en=0. memory_address holds its last value; it is don't-care.
- FILL, data return:
  - Any cycle with memory_data_valid=1: write_data_array=1, word_index=ret_cnt, then ret_cnt increments.
  - The block is latency-agnostic; it counts valid returns, not cycles. Returns may overlap with the issue phase.
- Completion:
  - The cycle that memory_data_valid=1 with ret_cnt=7 also asserts write_tag_array=1 and fill_done=1, alongside the final data write.
  - The next state is IDLE.
  - fsm_busy stays 1 during that completion cycle and is 0 in the following IDLE cycle unless a new miss is present.
- Timing with memory latency 4:
  - Miss at cycle 0.
  - Issues in cycles 1-8, returns in cycles 5-12.
  - fill_done at cycle 12; IDLE at cycle 13.
- Boundary conditions:
  - miss_detected toggling or miss_address changing during FILL: ignored, because base_addr is latched.
  - Back-to-back misses: a miss present in the first IDLE cycle after completion is accepted immediately.
  - Reset mid-fill: the next cycle is IDLE with all outputs 0. Late memory returns after reset are ignored.
  - Address wrap: base_addr of 16'hFFF0 issues FFF0 through FFFE with no wrap past FFFE. The adder is 16 bits and carry-out is discarded.
  - A valid return when ret_cnt would exceed 7 cannot occur, because the FSM leaves FILL on word 7.
  - memory_data is not registered. The cache data array takes it directly, qualified by write_data_array.

Decomposition:
- Shared package holds:
  - state encodings ST_IDLE=1'b0 and ST_FILL=1'b1;
  - WORDS_PER_BLOCK=8;
  - BLOCK_OFFSET_MASK=16'hFFF0;
  - WORD_IDX_W=3.
- One sub-module, fill_counter: 4-bit counter with synchronous clear, enable, and terminal flag at 8.
  - Instantiated twice, once as issue_cnt and once as ret_cnt.
- Address offset addition reuses the existing full_adder, with cin=0.

Test Plan:
1. Reset, then a miss at 16'h1234 with memory latency 4: addresses 1230, 1232, ..., 123E issued in cycles 1-8. write_data_array in cycles 5-12 with word_index 0-7. write_tag_array and fill_done pulse only in cycle 12. fsm_busy=1 in cycles 0-12, and 0 in cycle 13.
2. A memory model with variable gaps in memory_data_valid (returns at cycles 5, 7, 8, 11, ...): word_index increments only on valid returns. fill_done coincides with the 8th valid return.
3. miss_address changed to 16'h8000 and miss_detected dropped mid-fill: all 8 issued addresses remain 1230-123E, and the fill completes normally.
4. rst_n=0 asserted at cycle 6 of a fill: the next cycle has all outputs 0 and the state is IDLE. Valid returns in cycles 7-12 produce no write_data_array. A new miss is then serviced from word 0.
5. miss_detected held high across completion with miss_address 16'hFFF4: a second fill starts in cycle 13 with addresses FFF0-FFFE. memory_address never exceeds FFFE.
